// File: rtl/regex_instr_mem_arbiter_if.sv
// Fetch and host-load bus between the CPU array / host and the
// shared instruction memory responder.
interface regex_instr_mem_arbiter_if #(
    parameter int NUM_PORTS         = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
);
    logic [NUM_PORTS-1:0]                   memory_valid;
    logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr;
    logic [NUM_PORTS-1:0]                   memory_ready;
    logic [NUM_PORTS*MEMORY_WIDTH-1:0]      memory_data;
    logic                                   load_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]           load_addr;
    logic [MEMORY_WIDTH-1:0]                load_data;
    logic                                   load_ready;

    modport master (
        output memory_valid, memory_addr,
        output load_valid, load_addr, load_data,
        input  memory_ready, memory_data, load_ready
    );

    modport slave (
        input  memory_valid, memory_addr,
        input  load_valid, load_addr, load_data,
        output memory_ready, memory_data, load_ready
    );
endinterface

// File: rtl/regex_instr_mem_arbiter.sv
// Shared instruction RAM: round-robin fetch arbitration across CPU
// ports, host load port with priority, per-port held read data.
module regex_instr_mem_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input logic                      clk,
    input logic                      rst,
    regex_instr_mem_arbiter_if.slave bus
);

    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DEPTH = 1 << MEMORY_ADDR_WIDTH;
    localparam int W     = MEMORY_WIDTH;
    localparam int AW    = MEMORY_ADDR_WIDTH;

    logic [W-1:0]           ram [DEPTH];
    logic [W-1:0]           ram_q;
    logic [W-1:0]           hold [NUM_PORTS];
    logic [PW-1:0]          last_grant;
    logic [PW-1:0]          rd_port;
    logic                   rd_pending;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          cand;
    logic                   grant_hit;
    logic                   load_fire;
    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS-1:0]   grant;
    logic [AW-1:0]          fetch_addr;
    logic [NUM_PORTS*W-1:0] data_out;

    // Loads win the cycle; fetches are masked while loading or in reset.
    assign load_fire = bus.load_valid && !rst;
    assign req = bus.memory_valid
               & {NUM_PORTS{!rst && !bus.load_valid}};

    // Round-robin search starting just after the last accepted port.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PW'((int'(last_grant) + k) % NUM_PORTS);
            if (!grant_hit && req[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant = grant_hit
                 ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx)
                 : '0;

    assign bus.memory_ready = grant;
    assign bus.load_ready   = !rst;

    assign fetch_addr =
        bus.memory_addr[int'(grant_idx)*AW +: AW];

    // Single-port RAM: host write or granted read, never both in one cycle.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            ram[bus.load_addr] <= bus.load_data;
        end
        if (grant_hit) begin
            ram_q <= ram[fetch_addr];
        end
    end

    // Arbitration pointer, in-flight read tracking and per-port hold capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PW'(NUM_PORTS - 1);
            rd_pending <= 1'b0;
            rd_port    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            if (rd_pending) begin
                hold[rd_port] <= ram_q;
            end
            rd_pending <= grant_hit;
            if (grant_hit) begin
                rd_port    <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // The port with a read in flight sees RAM output; others see their hold.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rd_pending && rd_port == PW'(i)) begin
                data_out[i*W +: W] = ram_q;
            end else begin
                data_out[i*W +: W] = hold[i];
            end
        end
    end

    assign bus.memory_data = data_out;

endmodule

// File: tb/tb_regex_instr_mem_arbiter.sv
// Bench for regex_instr_mem_arbiter: directed scenarios plus random
// traffic checked against a transaction-level memory/arbiter model.
module tb_regex_instr_mem_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regex_instr_mem_arbiter_if #(
        .NUM_PORTS(N),
        .MEMORY_WIDTH(W),
        .MEMORY_ADDR_WIDTH(AW)
    ) bus ();

    regex_instr_mem_arbiter #(
        .NUM_PORTS(N),
        .MEMORY_WIDTH(W),
        .MEMORY_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [N-1:0]    mv;
    logic [AW-1:0]   ma [N];
    logic            lv;
    logic [AW-1:0]   la;
    logic [W-1:0]    ld;
    logic [N*AW-1:0] addr_flat;

    always_comb begin
        addr_flat = '0;
        for (int i = 0; i < N; i++) begin
            addr_flat[i*AW +: AW] = ma[i];
        end
    end

    assign bus.memory_valid = mv;
    assign bus.memory_addr  = addr_flat;
    assign bus.load_valid   = lv;
    assign bus.load_addr    = la;
    assign bus.load_data    = ld;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mem_m [2**AW];
    logic [W-1:0] exp_data [N];
    int           last_m;
    int           wait_f [N];
    int           glog [$];
    int           mode;
    logic [N-1:0] ready_seen;
    int           sz;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pd(input int i);
        return bus.memory_data[i*W +: W];
    endfunction

    task automatic reset_model();
        last_m = N - 1;
        for (int i = 0; i < N; i++) begin
            exp_data[i] = '0;
            wait_f[i]   = 0;
        end
    endtask

    function automatic int model_grant();
        int p;
        if (rst || lv) return -1;
        for (int k = 1; k <= N; k++) begin
            p = (last_m + k) % N;
            if (mv[p]) return p;
        end
        return -1;
    endfunction

    task automatic cyc();
        int g;
        logic [31:0] er;
        @(negedge clk);
        g = model_grant();
        er = (g < 0) ? 32'd0 : (32'd1 << g);
        ready_seen = bus.memory_ready;
        check("ready", 32'(bus.memory_ready), er);
        check("load_ready", 32'(bus.load_ready), 32'(!rst));
        for (int i = 0; i < N; i++) begin
            check($sformatf("data%0d", i), 32'(pd(i)), 32'(exp_data[i]));
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            if (lv) begin
                mem_m[la] = ld;
            end else if (g >= 0) begin
                exp_data[g] = mem_m[ma[g]];
                last_m = g;
                glog.push_back(g);
                check("starve", 32'(wait_f[g] < N), 32'd1);
                wait_f[g] = 0;
                for (int i = 0; i < N; i++) begin
                    if (i != g && mv[i]) wait_f[i]++;
                end
                if (mode == 0) begin
                    mv[g] = 1'b0;
                end else if (mode == 2) begin
                    if ($urandom_range(0, 1) == 0) mv[g] = 1'b0;
                    else ma[g] = AW'($urandom_range(0, 63));
                end
            end
        end
    endtask

    task automatic run_until_idle(input int max);
        for (int c = 0; c < max && mv != '0; c++) cyc();
        check("drain", 32'(mv), 32'd0);
    endtask

    initial begin
        mv = '0;
        for (int i = 0; i < N; i++) ma[i] = '0;
        lv = 1'b0;
        la = '0;
        ld = '0;
        mode = 0;
        for (int a = 0; a < 2**AW; a++) mem_m[a] = '0;
        reset_model();
        #1 rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;

        // preload addresses 0..63 and the top address
        for (int a = 0; a < 64; a++) begin
            lv = 1'b1;
            la = AW'(a);
            if (a < 3) ld = W'(a + 1);
            else if (a == 5) ld = 16'hA161;
            else ld = W'($urandom);
            cyc();
        end
        la = 11'h7FF;
        ld = 16'hFFFF;
        cyc();
        lv = 1'b0;

        // contention: all four ports hold distinct addresses
        mode = 1;
        mv = '1;
        ma[0] = 11'd10;
        ma[1] = 11'd20;
        ma[2] = 11'd30;
        ma[3] = 11'd40;
        sz = glog.size();
        repeat (8) cyc();
        mv = '0;
        for (int k = 0; k < 8; k++) begin
            check("rr_order",
                  (glog.size() > sz + k) ? 32'(glog[sz+k]) : 32'hFFFF_FFFF,
                  32'(k % 4));
        end
        cyc();

        // load then fetch, held for ten cycles
        mode = 0;
        mv[0] = 1'b1;
        ma[0] = 11'd5;
        cyc();
        check("lf_grant", 32'(glog[$]), 32'd0);
        repeat (10) begin
            cyc();
            check("lf_hold", 32'(pd(0)), 32'hA161);
        end

        // load priority: three load cycles stall port 2
        mv[2] = 1'b1;
        ma[2] = 11'd7;
        for (int k = 0; k < 3; k++) begin
            lv = 1'b1;
            la = 11'd7;
            ld = W'(16'h5A5A + k);
            cyc();
            check("lp_stall", 32'(ready_seen), 32'd0);
        end
        lv = 1'b0;
        cyc();
        check("lp_grant", 32'(glog[$]), 32'd2);
        check("lp_data", 32'(pd(2)), 32'h5A5C);

        // back-to-back fetches from port 1
        mv[1] = 1'b1;
        ma[1] = 11'd0;
        cyc();
        check("b2b_0", 32'(pd(1)), 32'h0001);
        mv[1] = 1'b1;
        ma[1] = 11'd1;
        cyc();
        check("b2b_1", 32'(pd(1)), 32'h0002);
        mv[1] = 1'b1;
        ma[1] = 11'd2;
        cyc();
        check("b2b_2", 32'(pd(1)), 32'h0003);

        // top address on port 3, port 0 keeps its word
        mv[3] = 1'b1;
        ma[3] = 11'h7FF;
        cyc();
        check("top_data", 32'(pd(3)), 32'hFFFF);
        check("top_p0", 32'(pd(0)), 32'hA161);

        // reset the cycle after an acceptance
        mv[1] = 1'b1;
        ma[1] = 11'd5;
        cyc();
        rst = 1'b1;
        reset_model();
        #1;
        check("rst_ready", 32'(bus.memory_ready), 32'd0);
        check("rst_lready", 32'(bus.load_ready), 32'd0);
        check("rst_data", bus.memory_data[31:0], 32'd0);
        check("rst_data_hi", bus.memory_data[63:32], 32'd0);
        repeat (2) cyc();
        rst = 1'b0;
        mv = '1;
        for (int i = 0; i < N; i++) ma[i] = 11'd5;
        sz = glog.size();
        run_until_idle(10);
        check("rst_first",
              (glog.size() > sz) ? 32'(glog[sz]) : 32'hFFFF_FFFF,
              32'd0);
        cyc();
        check("rst_refetch", 32'(pd(1)), 32'hA161);

        // random traffic
        mode = 2;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && $urandom_range(0, 2) == 0) begin
                    mv[i] = 1'b1;
                    ma[i] = AW'($urandom_range(0, 63));
                end
            end
            lv = ($urandom_range(0, 4) == 0);
            la = AW'($urandom_range(0, 63));
            ld = W'($urandom);
            cyc();
        end
        lv = 1'b0;
        mode = 0;
        run_until_idle(40);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
